// File: rtl/imem_loader.sv
// imem_loader: streams file-reader words into instruction memory at
// consecutive word addresses, holds the CPU in reset until the program
// is loaded plus a settling delay, and reloads on a Start pulse.
module imem_loader #(
    parameter int          DEPTH_LOG2    = 8,
    parameter logic [31:0] BASE_ADDR     = 32'h0040_0000,
    parameter int          RELEASE_DELAY = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [31:0]           Word_in,
    input  logic                  Word_valid,
    input  logic                  End_file,
    input  logic                  Start,
    output logic                  Mem_wr,
    output logic [31:0]           Mem_addr,
    output logic [31:0]           Mem_wdata,
    output logic                  Cpu_rst,
    output logic                  Load_done,
    output logic [DEPTH_LOG2:0]   Word_count,
    output logic                  Overflow
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
    // Delay counter only has to reach RELEASE_DELAY-1.
    localparam int DW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [DW-1:0] DLAST = DW'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {LOAD, HOLD, RUN, ERROR} state_t;

    state_t        state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          wr_n, ovf_n;
    logic [31:0]   addr_n, wdata_n;
    logic [CW-1:0] count_n;

    // State and all registered outputs; Rst returns everything to load-start values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= LOAD;
            dcnt       <= '0;
            Mem_wr     <= 1'b0;
            Mem_addr   <= BASE_ADDR;
            Mem_wdata  <= '0;
            Cpu_rst    <= 1'b0;
            Load_done  <= 1'b0;
            Word_count <= '0;
            Overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            dcnt       <= dcnt_n;
            Mem_wr     <= wr_n;
            Mem_addr   <= addr_n;
            Mem_wdata  <= wdata_n;
            Cpu_rst    <= (state_n == RUN);
            Load_done  <= (state_n == RUN);
            Word_count <= count_n;
            Overflow   <= ovf_n;
        end
    end

    // Next-state and next-output values; address/data hold when idle.
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        wr_n    = 1'b0;
        addr_n  = Mem_addr;
        wdata_n = Mem_wdata;
        count_n = Word_count;
        ovf_n   = Overflow;
        case (state)
            LOAD: begin
                if (Word_valid && (Word_count == CAP)) begin
                    // Overflow wins over a simultaneous End_file.
                    ovf_n   = 1'b1;
                    state_n = ERROR;
                end else begin
                    if (Word_valid) begin
                        wr_n    = 1'b1;
                        wdata_n = Word_in;
                        addr_n  = BASE_ADDR + (32'(Word_count) << 2);
                        count_n = Word_count + 1'b1;
                    end
                    if (End_file) begin
                        state_n = HOLD;
                        dcnt_n  = '0;
                    end
                end
            end
            HOLD: begin
                if (dcnt == DLAST) state_n = RUN;
                else               dcnt_n  = dcnt + 1'b1;
            end
            RUN, ERROR: begin
                if (Start) begin
                    state_n = LOAD;
                    count_n = '0;
                    ovf_n   = 1'b0;
                    addr_n  = BASE_ADDR;
                end
            end
            default: state_n = LOAD;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default-depth instance plus a 4-word
// instance for the overflow scenario, sharing clock and stimulus.
module tb_imem_loader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] Word_in = '0;
    logic        Word_valid = 1'b0;
    logic        End_file = 1'b0;
    logic        Start = 1'b0;

    logic        b_wr, b_cpu, b_done, b_ovf;
    logic [31:0] b_addr, b_wdata;
    logic [8:0]  b_cnt;
    logic        s_wr, s_cpu, s_done, s_ovf;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] BASE = 32'h0040_0000;

    imem_loader u_big (
        .Clk(Clk), .Rst(Rst), .Word_in(Word_in), .Word_valid(Word_valid),
        .End_file(End_file), .Start(Start), .Mem_wr(b_wr), .Mem_addr(b_addr),
        .Mem_wdata(b_wdata), .Cpu_rst(b_cpu), .Load_done(b_done),
        .Word_count(b_cnt), .Overflow(b_ovf)
    );

    imem_loader #(.DEPTH_LOG2(2)) u_small (
        .Clk(Clk), .Rst(Rst), .Word_in(Word_in), .Word_valid(Word_valid),
        .End_file(End_file), .Start(Start), .Mem_wr(s_wr), .Mem_addr(s_addr),
        .Mem_wdata(s_wdata), .Cpu_rst(s_cpu), .Load_done(s_done),
        .Word_count(s_cnt), .Overflow(s_ovf)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Word_valid = 0; End_file = 0; Start = 0; Word_in = '0;
        Rst = 0;
        tick(); tick();
        Rst = 1;
    endtask

    task automatic test_reset;
        Rst = 0;
        tick(); tick();
        checks++;
        if ({b_wr, b_addr, b_wdata, b_cpu, b_done, b_cnt, b_ovf} !==
            {1'b0, BASE, 32'h0, 1'b0, 1'b0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_big: wr=%b addr=%h wdata=%h cpu=%b done=%b cnt=%0d ovf=%b", b_wr, b_addr, b_wdata, b_cpu, b_done, b_cnt, b_ovf);
        end
        checks++;
        if ({s_wr, s_addr, s_cpu, s_cnt, s_ovf} !== {1'b0, BASE, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_small: wr=%b addr=%h cpu=%b cnt=%0d ovf=%b", s_wr, s_addr, s_cpu, s_cnt, s_ovf);
        end
        Rst = 1;
    endtask

    task automatic test_three_words;
        logic [31:0] w [3];
        w[0] = 32'h0050_0093; w[1] = 32'h00A0_0113; w[2] = 32'h0020_81B3;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            Word_valid = 1; Word_in = w[i];
            tick();
            checks++;
            if (b_wr !== 1'b1 || b_addr !== BASE + 32'(4*i) || b_wdata !== w[i]) begin
                errors++;
                $display("FAIL three_write%0d: wr=%b addr=%h data=%h want addr=%h data=%h", i, b_wr, b_addr, b_wdata, BASE + 32'(4*i), w[i]);
            end
        end
        Word_valid = 0; End_file = 1;
        tick();
        End_file = 0;
        checks++;
        if (b_wr !== 1'b0 || b_cnt !== 9'd3 || b_cpu !== 1'b0) begin
            errors++;
            $display("FAIL three_eof: wr=%b cnt=%0d cpu=%b want 0 3 0", b_wr, b_cnt, b_cpu);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (b_cpu !== (k == 4) || b_done !== (k == 4)) begin
                errors++;
                $display("FAIL three_release_e%0d: cpu=%b done=%b want %b", k, b_cpu, b_done, (k == 4));
            end
        end
    endtask

    task automatic test_gaps;
        logic [3:0]  pat;
        int          n;
        pat = 4'b1001;
        n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            Word_valid = pat[3-i]; Word_in = 32'h1000 + 32'(i);
            tick();
            checks++;
            if (b_wr !== pat[3-i] || b_addr !== BASE + 32'(4*(pat[3-i] ? n : n-1))) begin
                errors++;
                $display("FAIL gaps_cyc%0d: wr=%b addr=%h want wr=%b addr=%h", i, b_wr, b_addr, pat[3-i], BASE + 32'(4*(pat[3-i] ? n : n-1)));
            end
            if (pat[3-i]) n++;
        end
        Word_valid = 1; End_file = 1; Word_in = 32'hDEAD_BEEF;
        tick();
        Word_valid = 0; End_file = 0;
        checks++;
        if (b_wr !== 1'b1 || b_addr !== 32'h0040_0008 || b_wdata !== 32'hDEAD_BEEF || b_cnt !== 9'd3) begin
            errors++;
            $display("FAIL gaps_last: wr=%b addr=%h data=%h cnt=%0d want 1 00400008 deadbeef 3", b_wr, b_addr, b_wdata, b_cnt);
        end
        repeat (4) tick();
        checks++;
        if (b_cpu !== 1'b1) begin
            errors++;
            $display("FAIL gaps_run: cpu=%b want 1", b_cpu);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            Word_valid = 1; Word_in = 32'hA000 + 32'(i);
            tick();
            checks++;
            if (i < 4) begin
                if (s_wr !== 1'b1 || s_addr !== BASE + 32'(4*i) || s_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_write%0d: wr=%b addr=%h ovf=%b", i, s_wr, s_addr, s_ovf);
                end
            end else begin
                if (s_wr !== 1'b0 || s_ovf !== 1'b1 || s_cpu !== 1'b0 || s_addr !== 32'h0040_000C) begin
                    errors++;
                    $display("FAIL ovf_word%0d: wr=%b ovf=%b cpu=%b addr=%h want 0 1 0 0040000c", i, s_wr, s_ovf, s_cpu, s_addr);
                end
            end
        end
        Word_valid = 0; Start = 1;
        tick();
        Start = 0;
        checks++;
        if (s_ovf !== 1'b0 || s_cnt !== 3'd0 || s_addr !== BASE || s_done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_start: ovf=%b cnt=%0d addr=%h done=%b", s_ovf, s_cnt, s_addr, s_done);
        end
        Word_valid = 1; Word_in = 32'h11;
        tick();
        End_file = 1; Word_in = 32'h22;
        tick();
        Word_valid = 0; End_file = 0;
        checks++;
        if (s_wr !== 1'b1 || s_addr !== 32'h0040_0004 || s_wdata !== 32'h22 || s_cnt !== 3'd2) begin
            errors++;
            $display("FAIL ovf_reload: wr=%b addr=%h data=%h cnt=%0d", s_wr, s_addr, s_wdata, s_cnt);
        end
        repeat (4) tick();
        checks++;
        if (s_done !== 1'b1 || s_cpu !== 1'b1 || s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reload_run: done=%b cpu=%b ovf=%b want 1 1 0", s_done, s_cpu, s_ovf);
        end
    endtask

    task automatic test_run_reload;
        do_reset();
        Word_valid = 1; Word_in = 32'h5;
        tick();
        End_file = 1; Word_in = 32'h6;
        tick();
        Word_valid = 0; End_file = 0;
        repeat (4) tick();
        checks++;
        if (b_cpu !== 1'b1 || b_addr !== 32'h0040_0004) begin
            errors++;
            $display("FAIL reload_pre: cpu=%b addr=%h want 1 00400004", b_cpu, b_addr);
        end
        Start = 1;
        tick();
        Start = 0;
        checks++;
        if (b_cpu !== 1'b0 || b_done !== 1'b0 || b_addr !== BASE || b_cnt !== 9'd0) begin
            errors++;
            $display("FAIL reload_start: cpu=%b done=%b addr=%h cnt=%0d", b_cpu, b_done, b_addr, b_cnt);
        end
        Word_valid = 1; Word_in = 32'h0000_0013;
        tick();
        Word_valid = 0;
        checks++;
        if (b_wr !== 1'b1 || b_addr !== BASE || b_wdata !== 32'h13 || b_cnt !== 9'd1) begin
            errors++;
            $display("FAIL reload_write: wr=%b addr=%h data=%h cnt=%0d", b_wr, b_addr, b_wdata, b_cnt);
        end
        End_file = 1;
        tick();
        End_file = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (b_cpu !== (k == 4)) begin
                errors++;
                $display("FAIL reload_release_e%0d: cpu=%b want %b", k, b_cpu, (k == 4));
            end
        end
    endtask

    task automatic test_midload_reset;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            Word_valid = 1; Word_in = 32'hB000 + 32'(i);
            tick();
        end
        Word_valid = 0;
        Rst = 0;
        #1;
        checks++;
        if ({b_wr, b_addr, b_wdata, b_cpu, b_done, b_cnt, b_ovf} !==
            {1'b0, BASE, 32'h0, 1'b0, 1'b0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL midreset: wr=%b addr=%h wdata=%h cpu=%b done=%b cnt=%0d ovf=%b", b_wr, b_addr, b_wdata, b_cpu, b_done, b_cnt, b_ovf);
        end
        Rst = 1;
        Word_valid = 1; Word_in = 32'hB002;
        tick();
        Word_valid = 0;
        checks++;
        if (b_wr !== 1'b1 || b_addr !== BASE || b_wdata !== 32'hB002 || b_cnt !== 9'd1) begin
            errors++;
            $display("FAIL midreset_restart: wr=%b addr=%h data=%h cnt=%0d", b_wr, b_addr, b_wdata, b_cnt);
        end
    endtask

    task automatic test_empty;
        do_reset();
        End_file = 1;
        tick();
        End_file = 0;
        checks++;
        if (b_wr !== 1'b0 || b_cnt !== 9'd0 || b_cpu !== 1'b0) begin
            errors++;
            $display("FAIL empty_eof: wr=%b cnt=%0d cpu=%b", b_wr, b_cnt, b_cpu);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (b_wr !== 1'b0 || b_cpu !== (k == 4) || b_ovf !== 1'b0) begin
                errors++;
                $display("FAIL empty_e%0d: wr=%b cpu=%b ovf=%b want 0 %b 0", k, b_wr, b_cpu, b_ovf, (k == 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_gaps();
        test_overflow();
        test_run_reload();
        test_midload_reset();
        test_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
